// File: rtl/sb_reg_file.sv
// Integer register file: NRD combinational read ports with write-through bypass, one write port,
// and a per-register busy scoreboard (set at issue, cleared at writeback). Register 0 is hardwired to zero.
module sb_reg_file #(
  parameter int              XLEN    = 32,
  parameter int              AW      = 5,
  parameter int              NRD     = 2,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0101_1111
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic [(2**AW)-1:0]    busy_vec
);

  localparam int NREG = 2**AW;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic wr_live;
  logic iss_live;

  assign wr_live  = wr_en  && (wr_addr  != '0);
  assign iss_live = iss_en && (iss_addr != '0);

  // Issue is applied after the write so a same-edge collision leaves the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_live) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_live) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] a;
      logic          hit;
      a   = rd_addr[k*AW +: AW];
      hit = wr_en && (wr_addr == a);
      if (a == '0) begin
        rd_data[k*XLEN +: XLEN] = '0;
      end else if (hit) begin
        rd_data[k*XLEN +: XLEN] = wr_data;
      end else begin
        rd_data[k*XLEN +: XLEN] = regs_q[a];
      end
      rd_busy[k] = busy_q[a] && !hit;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_sb_reg_file.sv
// Self-checking bench for sb_reg_file: directed vector table, reset corner cases, and randomized
// traffic compared against an array-based model of the register file and scoreboard.
`timescale 1ns/1ps
module tb_sb_reg_file;

  localparam logic [31:0] SP_INIT = 32'h0101_1111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [31:0] busy_vec;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  sb_reg_file dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] bv;
  } vec_t;

  vec_t tbl[10];

  // Reference model: plain arrays updated by the architectural rules.
  logic [31:0] m_reg [32];
  bit          m_busy [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = (i == 2) ? SP_INIT : 32'h0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return m_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd2, 32'hDEAD_BEEF, 1'b0, SP_INIT,      1'b0, 32'h0};
    tbl[1] = '{1'b0, 5'd5, 32'h0,         1'b0, 5'd0, 5'd5, 5'd0, 32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[2] = '{1'b1, 5'd0, 32'h1234,      1'b1, 5'd0, 5'd0, 5'd0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h0};
    tbl[3] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd7, 5'd0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h80};
    tbl[4] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd5, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h80};
    tbl[5] = '{1'b1, 5'd7, 32'h55,        1'b0, 5'd0, 5'd7, 5'd7, 32'h55,        1'b0, 32'h55,       1'b0, 32'h0};
    tbl[6] = '{1'b1, 5'd9, 32'hA5,        1'b1, 5'd9, 5'd9, 5'd7, 32'hA5,        1'b0, 32'h55,       1'b0, 32'h200};
    tbl[7] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd9, 5'd7, 32'hA5,        1'b1, 32'h55,       1'b0, 32'h200};
    tbl[8] = '{1'b1, 5'd3, 32'h77,        1'b1, 5'd3, 5'd3, 5'd9, 32'h77,        1'b0, 32'hA5,       1'b1, 32'h208};
    tbl[9] = '{1'b1, 5'd9, 32'h1,         1'b0, 5'd0, 5'd9, 5'd3, 32'h1,         1'b0, 32'h77,       1'b1, 32'h8};

    // Reset pulse entirely between edges (first posedge at t=10).
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy_vec", busy_vec, 32'h0);
    rd_addr = {5'd5, 5'd2};
    #1;
    chk("rst_r2", rd_data[31:0], SP_INIT);
    chk("rst_r5", rd_data[63:32], 32'h0);
    #1 reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'd0, 5'(a)};
      #0.1;
      chk($sformatf("rst_sweep_r%0d", a), rd_data[31:0], (a == 2) ? SP_INIT : 32'h0);
    end

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      iss_en = tbl[i].ie; iss_addr = tbl[i].ia;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #4;
      chk($sformatf("vec%0d_d0", i), rd_data[31:0], tbl[i].d0);
      chk($sformatf("vec%0d_b0", i), 32'(rd_busy[0]), 32'(tbl[i].b0));
      chk($sformatf("vec%0d_d1", i), rd_data[63:32], tbl[i].d1);
      chk($sformatf("vec%0d_b1", i), 32'(rd_busy[1]), 32'(tbl[i].b1));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy_vec", i), busy_vec, tbl[i].bv);
    end

    // Mid-operation reset: r3 is busy and holds 0x77.
    wr_en = 1'b0; iss_en = 1'b0; rd_addr = {5'd9, 5'd3};
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_r3", rd_data[31:0], 32'h0);
    chk("midrst_r9", rd_data[63:32], 32'h0);
    chk("midrst_busy_vec", busy_vec, 32'h0);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h99; iss_en = 1'b1; iss_addr = 5'd3;
    @(posedge clk); #1;
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    chk("midrst_write_lost", rd_data[31:0], 32'h0);
    chk("midrst_issue_lost", busy_vec, 32'h0);
    #2 reset_n = 1'b1;
    model_reset();

    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      logic [4:0] a0, a1;
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr_data  = $urandom;
      iss_en   = ($urandom_range(0, 2) != 0);
      iss_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a0 = 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 1) != 0) ? wr_addr : 5'($urandom);
      rd_addr = {a1, a0};
      #4;
      chk("rnd_d0", rd_data[31:0], exp_data(a0));
      chk("rnd_d1", rd_data[63:32], exp_data(a1));
      chk("rnd_b0", 32'(rd_busy[0]), 32'(exp_busy(a0)));
      chk("rnd_b1", 32'(rd_busy[1]), 32'(exp_busy(a1)));
      @(posedge clk);
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      #1;
      chk("rnd_busy_vec", busy_vec, exp_vec());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
